// File: rtl/data_deserializer.sv
// Serial frame deserializer: start/channel/16 data bits MSB first/stop, into a 4-entry FIFO.
// Optional saturating error counter on the err_count port when DESER_ERR_CNT_EN is defined.
//
// state   | meaning
// IDLE    | waiting for a start bit (in_bit=1)
// CHANNEL | sampling the channel tag bit
// DATA    | shifting in 16 data bits, MSB first
// STOP    | checking the stop bit (0 = good frame)
// RESYNC  | after a bad stop bit, waiting for the line to go low
module data_deserializer (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_bit,
    output logic [15:0] out_data,
    output logic        out_channel,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        frame_error,
    output logic        overflow
`ifdef DESER_ERR_CNT_EN
    ,
    output logic [15:0] err_count
`endif
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CHANNEL = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        RESYNC  = 3'd4
    } state_t;

    state_t      state;
    logic [15:0] shift;
    logic        channel;
    logic [3:0]  bit_idx;

    logic [16:0] mem [4];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [2:0]  count;

    logic push_req;
    logic push;
    logic pop;

    // A full FIFO still accepts a word when the head is popped on the same edge.
    assign push_req    = (state == STOP) && !in_bit;
    assign pop         = out_ready && (count != 3'd0);
    assign push        = push_req && ((count != 3'd4) || pop);

    assign out_valid   = (count != 3'd0);
    assign out_data    = mem[rd_ptr][15:0];
    assign out_channel = mem[rd_ptr][16];

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            shift       <= 16'd0;
            channel     <= 1'b0;
            bit_idx     <= 4'd0;
            frame_error <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            frame_error <= 1'b0;
            overflow    <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_bit)
                        state <= CHANNEL;
                end
                CHANNEL: begin
                    channel <= in_bit;
                    bit_idx <= 4'd15;
                    state   <= DATA;
                end
                DATA: begin
                    shift[bit_idx] <= in_bit;
                    bit_idx        <= bit_idx - 4'd1;
                    if (bit_idx == 4'd0)
                        state <= STOP;
                end
                STOP: begin
                    if (in_bit) begin
                        frame_error <= 1'b1;
                        state       <= RESYNC;
                    end else begin
                        overflow <= !push;
                        state    <= IDLE;
                    end
                end
                RESYNC: begin
                    if (!in_bit)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 3'd0;
            for (int i = 0; i < 4; i++)
                mem[i] <= 17'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {channel, shift};
                wr_ptr      <= wr_ptr + 2'd1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 2'd1;
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

`ifdef DESER_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            err_count <= 16'd0;
        else if ((frame_error || overflow) && (err_count != 16'hFFFF))
            err_count <= err_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_data_deserializer.sv
// Self-checking bench for data_deserializer: directed scenarios plus random frames
// checked every cycle against a queue-based model of the delivered words and pulses.
module tb_data_deserializer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_bit;
    logic [15:0] out_data;
    logic        out_channel;
    logic        out_valid;
    logic        out_ready;
    logic        frame_error;
    logic        overflow;
`ifdef DESER_ERR_CNT_EN
    logic [15:0] err_count;
`endif

    data_deserializer dut (
        .clk         (clk),
        .reset       (reset),
        .in_bit      (in_bit),
        .out_data    (out_data),
        .out_channel (out_channel),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .frame_error (frame_error),
        .overflow    (overflow)
`ifdef DESER_ERR_CNT_EN
        ,
        .err_count   (err_count)
`endif
    );

    always #5 clk = ~clk;

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [16:0] q[$];
    logic [16:0] pend;
    logic        exp_ferr;
    logic        exp_ovf;
    logic [15:0] exp_err;
    int          ferr_seen;
    int          ovf_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
        if (q.size() != 0) begin
            chk("out_data", {16'd0, out_data}, {16'd0, q[0][15:0]});
            chk("out_channel", {31'd0, out_channel}, {31'd0, q[0][16]});
        end
        chk("frame_error", {31'd0, frame_error}, {31'd0, exp_ferr});
        chk("overflow", {31'd0, overflow}, {31'd0, exp_ovf});
`ifdef DESER_ERR_CNT_EN
        chk("err_count", {16'd0, err_count}, {16'd0, exp_err});
`endif
    endtask

    // ev: 0 = ordinary bit, 1 = good stop bit (push pend), 2 = bad stop bit
    task automatic tick(input logic b, input logic rdy, input int ev);
        in_bit    = b;
        out_ready = rdy;
        @(posedge clk);
        if ((exp_ferr || exp_ovf) && exp_err != 16'hFFFF)
            exp_err = exp_err + 16'd1;
        if (rdy && q.size() != 0)
            void'(q.pop_front());
        exp_ferr = (ev == 2);
        exp_ovf  = 1'b0;
        if (ev == 1) begin
            if (q.size() < 4)
                q.push_back(pend);
            else
                exp_ovf = 1'b1;
        end
        ferr_seen += int'(exp_ferr);
        ovf_seen  += int'(exp_ovf);
        #1;
        check_outputs();
    endtask

    task automatic send_frame(input logic ch, input logic [15:0] data, input logic bad,
                              input logic rdy, input logic stop_rdy);
        tick(1'b1, rdy, 0);
        tick(ch, rdy, 0);
        for (int i = 15; i >= 0; i--)
            tick(data[i], rdy, 0);
        pend = {ch, data};
        tick(bad, stop_rdy, bad ? 2 : 1);
    endtask

    task automatic do_reset(input logic b);
        reset     = 1'b1;
        in_bit    = b;
        out_ready = 1'b0;
        @(posedge clk);
        q.delete();
        exp_ferr = 1'b0;
        exp_ovf  = 1'b0;
        exp_err  = 16'd0;
        #1;
        check_outputs();
        reset = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++)
            tick(1'b0, 1'b1, 0);
    endtask

    initial begin
        reset = 1'b1; in_bit = 1'b0; out_ready = 1'b0;
        exp_ferr = 1'b0; exp_ovf = 1'b0; exp_err = 16'd0;
        ferr_seen = 0; ovf_seen = 0;
        do_reset(1'b0);
        do_reset(1'b0);

        // single frame, first edge after reset is the start bit
        send_frame(1'b0, 16'hA5C3, 1'b0, 1'b1, 1'b1);
        drain(3);

        // back-to-back frames with no idle gap
        send_frame(1'b1, 16'h0001, 1'b0, 1'b1, 1'b1);
        send_frame(1'b0, 16'hFFFE, 1'b0, 1'b1, 1'b1);
        drain(3);

        // five frames with consumer stalled: one overflow, four kept
        for (int k = 0; k < 5; k++)
            send_frame(k[0], 16'h1000 + 16'(k), 1'b0, 1'b0, 1'b0);
        chk("overflow_pulses", ovf_seen, 1);
        drain(6);

        // bad stop bit, line stuck high, then recovery
        send_frame(1'b1, 16'hBEEF, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 40; i++)
            tick(1'b1, 1'b1, 0);
        tick(1'b0, 1'b1, 0);
        send_frame(1'b0, 16'h1234, 1'b0, 1'b1, 1'b1);
        drain(3);
        chk("frame_error_pulses", ferr_seen, 1);

        // reset at data bit 7 discards the partial frame
        tick(1'b1, 1'b1, 0);
        tick(1'b1, 1'b1, 0);
        for (int i = 15; i >= 8; i--)
            tick(1'b1, 1'b1, 0);
        do_reset(1'b1);
        send_frame(1'b0, 16'h00FF, 1'b0, 1'b1, 1'b1);
        drain(3);

        // full FIFO with a pop on the stop edge accepts the new word
        ovf_seen = 0;
        for (int k = 0; k < 4; k++)
            send_frame(1'b1, 16'h2000 + 16'(k), 1'b0, 1'b0, 1'b0);
        send_frame(1'b0, 16'h2ABC, 1'b0, 1'b0, 1'b1);
        chk("full_pop_no_overflow", ovf_seen, 0);
        drain(6);

        // random frames, gaps, stalls and bad stops
        for (int f = 0; f < 60; f++) begin
            logic bad;
            bad = ($urandom_range(0, 7) == 0);
            send_frame(1'($urandom), 16'($urandom), bad, 1'($urandom_range(0, 3) == 0),
                       1'($urandom));
            if (bad) begin
                for (int i = $urandom_range(0, 5); i > 0; i--)
                    tick(1'b1, 1'($urandom), 0);
                tick(1'b0, 1'($urandom), 0);
            end
            for (int i = $urandom_range(0, 2); i > 0; i--)
                tick(1'b0, 1'($urandom), 0);
        end
        drain(6);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
